systolic_feed_sequencer: RTL
============================

Name: systolic_feed_sequencer

Overview:
- Reads the LANES per-lane operand RAMs in lockstep and streams one LANES-wide word per beat into the west/north edge of the 4x4 systolic array.
- Each RAM has 16-bit words, a 4-bit address, registered read output, and read data that updates only when en is high.
- The RAMs are preloaded with skewed, zero-padded operand sequences. This block generates the shared address and enable, absorbs the 1-cycle RAM read latency, and applies valid/ready backpressure from the array.
- Sits directly upstream of the array and downstream of the operand RAMs.

Parameters:
- DATA_W, 16, width of one RAM word / one lane.
- ADDR_W, 4, RAM address width.
- LANES, 4, number of RAMs read in parallel (array edge width).
- SEQ_LEN, 16, addresses streamed per run (0..SEQ_LEN-1); must satisfy 1 <= SEQ_LEN <= 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; ignored unless IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted.
- ram_en  out  1  shared read enable to all LANES RAMs.
- ram_we  out  1  shared write enable; constant 0.
- ram_addr  out  ADDR_W  shared read address.
- ram_do  in  LANES*DATA_W  concatenated RAM outputs; lane i at bits [i*DATA_W +: DATA_W].
- feed_data  out  LANES*DATA_W  word presented to the array; same lane packing as ram_do.
- feed_valid  out  1  feed_data is valid.
- feed_ready  in  1  array accepts feed_data this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high; it dominates all other inputs.
- Reset values: state=IDLE, out_idx=0, busy=0, done=0, feed_valid=0. ram_en=0 and ram_addr=0 while in reset. Reset mid-run abandons the run; there is no done pulse and no further ram_en.
- Registered outputs: busy, done, feed_valid.
- Combinational outputs: ram_en and ram_addr, decoded from state, out_idx and feed_ready. feed_data is a direct passthrough of ram_do; the RAM output register is the data pipeline stage.
- State machine:
  - IDLE: ram_en=0. On start, go to PRIME; out_idx<=0; busy<=1.
  - PRIME (1 cycle): ram_en=1, ram_addr=0. Go to STREAM; feed_valid<=1.
  - STREAM: feed_valid=1. A beat is a cycle with feed_valid && feed_ready.
    - Beat with out_idx<SEQ_LEN-1: ram_en=1, ram_addr=out_idx+1, out_idx++.
    - Beat with out_idx==SEQ_LEN-1: ram_en=0, feed_valid<=0, busy<=0, done<=1, go to DONE.
    - No beat (feed_ready=0): ram_en=0. RAM output holds, so feed_data holds stable; no data loss, no rereads.
  - DONE (1 cycle): done=1, then go to IDLE; done<=0.
- Latency with feed_ready tied 1:
  - start sampled at edge T: PRIME in cycle T+1.
  - feed_valid high cycles T+2 .. T+SEQ_LEN+1, carrying addresses 0..SEQ_LEN-1 in order.
  - done high in cycle T+SEQ_LEN+2.
  - Next start accepted in cycle T+SEQ_LEN+3 (back-to-back runs permitted from IDLE).
- Boundaries:
  - start while busy or in DONE: ignored.
  - SEQ_LEN=1: exactly one beat, then done.
  - out_idx never wraps. ram_addr never exceeds SEQ_LEN-1.
  - feed_ready high outside STREAM: no effect.
  - Zero words are streamed like any other; no zero skipping.

Decomposition:
- Shared package systolic_pkg: DATA_W, ADDR_W, LANES, ARRAY_DIM=4, and the state encoding (IDLE, PRIME, STREAM, DONE).
- No sub-module needed. The lane pack/unpack is plain slicing inside this block.

Test Plan:
- Nominal run: model 4 RAMs with registered read (one lane loaded 0,0,0,0,0,1,4,7,2,5,8,3,6,9,0,0); start=1 for 1 cycle with feed_ready=1 -> 16 beats in address order 0..15, that lane yields the listed sequence, done pulses exactly once 18 cycles after start.
- Backpressure: same load; feed_ready low on beats 3 (2 cycles) and 9 (1 cycle) -> feed_data stable while stalled, ram_en=0 during stalls, still 16 beats in order with no duplicates or gaps, done 3 cycles later than nominal.
- start ignored: assert start in cycles 5 and 10 of a run -> no restart, beat count stays 16, single done.
- Reset mid-run: rst at beat 7 -> next cycle busy=0, feed_valid=0, ram_en=0, no done; new start then yields a full clean 16-beat run.
- Back-to-back: start again in the cycle after done -> second run begins in the following cycle with identical timing; ram_we is 0 throughout.
- SEQ_LEN=1 build: start -> exactly one beat at address 0, done 3 cycles after start.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and state encoding for the systolic array feed path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package systolic_pkg;

   localparam int DATA_W    = 16;  // one RAM word / one array lane
   localparam int ADDR_W    = 4;   // operand RAM address width
   localparam int LANES     = 4;   // RAMs read in lockstep (array edge width)
   localparam int ARRAY_DIM = 4;   // systolic array is ARRAY_DIM x ARRAY_DIM

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PRIME  = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } seq_state_e;

endpackage

// File: rtl/systolic_feed_sequencer.sv
// Streams SEQ_LEN lockstep words from LANES operand RAMs into the systolic array edge.
// Latency: first feed_valid 2 cycles after start; done one cycle after the last accepted beat.
// Backpressure: feed_ready low freezes the address and RAM enable, so the RAM output (feed_data) holds.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           one-cycle run request, honoured only in IDLE
//   busy, done      run in progress / one-cycle completion pulse
//   ram_en/we/addr  shared control to all operand RAMs (we is tied low)
//   ram_do          concatenated RAM outputs, lane i at [i*DATA_W +: DATA_W]
//   feed_data/valid/ready  valid/ready stream toward the array, same lane packing
module systolic_feed_sequencer #(
   parameter int DATA_W  = systolic_pkg::DATA_W,
   parameter int ADDR_W  = systolic_pkg::ADDR_W,
   parameter int LANES   = systolic_pkg::LANES,
   parameter int SEQ_LEN = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      ram_en,
   output logic                      ram_we,
   output logic [ADDR_W-1:0]         ram_addr,
   input  logic [LANES*DATA_W-1:0]   ram_do,
   output logic [LANES*DATA_W-1:0]   feed_data,
   output logic                      feed_valid,
   input  logic                      feed_ready
);

   import systolic_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SEQ_LEN - 1);

   seq_state_e          state_q, state_d;
   logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                feed_valid_q, feed_valid_d;

   logic                beat;
   logic                last_beat;

   // out_idx tracks the address whose data is currently on ram_do.
   assign beat      = (state_q == ST_STREAM) && feed_valid_q && feed_ready;
   assign last_beat = beat && (out_idx_q == LAST_IDX);

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         out_idx_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         feed_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_idx_q    <= out_idx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         feed_valid_q <= feed_valid_d;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      out_idx_d    = out_idx_q;
      busy_d       = busy_q;
      done_d       = done_q;
      feed_valid_d = feed_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_PRIME;
               out_idx_d = '0;
               busy_d    = 1'b1;
            end
         end
         ST_PRIME: begin
            state_d      = ST_STREAM;
            feed_valid_d = 1'b1;
         end
         ST_STREAM: begin
            if (last_beat) begin
               state_d      = ST_DONE;
               feed_valid_d = 1'b0;
               busy_d       = 1'b0;
               done_d       = 1'b1;
            end else if (beat) begin
               out_idx_d = out_idx_q + ADDR_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Output decode
   // ---------------------------------------------------------------
   // The RAM read is issued one cycle ahead of the beat that consumes it:
   // PRIME fetches address 0, and each non-final beat fetches the next one.
   // Holding en low on a stall keeps the RAM output register (feed_data) frozen.
   always_comb begin
      ram_en   = 1'b0;
      ram_addr = '0;
      if (!rst) begin
         case (state_q)
            ST_PRIME: begin
               ram_en = 1'b1;
            end
            ST_STREAM: begin
               if (beat && !last_beat) begin
                  ram_en   = 1'b1;
                  ram_addr = out_idx_q + ADDR_W'(1);
               end
            end
            default: begin
               ram_en = 1'b0;
            end
         endcase
      end
   end

   assign ram_we     = 1'b0;
   assign busy       = busy_q;
   assign done       = done_q;
   assign feed_valid = feed_valid_q;
   assign feed_data  = ram_do;

endmodule
